// File: rtl/piso_pkg.sv
// piso_pkg: shared types for the parallel-in/serial-out serializer.
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: captures a DEPTH-word vector and streams it out highest index first,
// so a downstream delay line of equal depth ends up holding the vector index-for-index.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_load_valid,
    input  logic [DEPTH-1:0][WIDTH-1:0]  i_load_data,
    output logic                         o_load_ready,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_last,
    input  logic                         i_ready
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t                       state;
    logic [IW-1:0]                idx;
    logic [DEPTH-1:0][WIDTH-1:0]  vec;
    logic                         beat, load;

    assign o_valid      = state == SHIFT;
    assign o_last       = o_valid && idx == '0;
    assign beat         = o_valid && i_ready;
    assign o_load_ready = state == IDLE || (beat && o_last);
    assign load         = i_load_valid && o_load_ready;

    // Compare-select rather than direct indexing keeps DEPTH=1 free of zero-width index issues.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (idx == IW'(i)) o_data = vec[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            idx   <= '0;
            vec   <= '0;
        end else if (load) begin
            state <= SHIFT;
            idx   <= IW'(DEPTH - 1);
            vec   <= i_load_data;
        end else if (beat) begin
            if (idx == '0) state <= IDLE;
            else           idx   <= idx - 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table-driven directed sequences plus randomized traffic checked
// against a word-queue reference model, for DEPTH=4 and DEPTH=1 instances.
module tb_piso_serializer;
    logic        clk = 0;
    logic        rst_n;
    logic        lv, rdy;
    logic [31:0] d;
    logic        lr, v, l;
    logic [7:0]  q;
    logic        lr1, v1, l1;
    logic [7:0]  q1;
    logic [31:0] sr;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(lv), .i_load_data(d),
        .o_load_ready(lr), .o_valid(v), .o_data(q), .o_last(l), .i_ready(rdy)
    );

    piso_serializer #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(lv), .i_load_data(d[7:0]),
        .o_load_ready(lr1), .o_valid(v1), .o_data(q1), .o_last(l1), .i_ready(rdy)
    );

    // Downstream delay line: newest word enters index 0, older words move up.
    always @(posedge clk or negedge rst_n)
        if (!rst_n)          sr <= '0;
        else if (v && rdy)   sr <= {sr[23:0], q};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        lv;
        logic        rdy;
        logic [31:0] d;
        logic        v;
        logic [7:0]  q;
        logic        l;
        logic        lr;
    } row_t;

    localparam logic [31:0] V1 = 32'h44332211;
    localparam logic [31:0] V2 = 32'h0D0C0B0A;

    row_t tbl[18];
    logic [7:0] mq[$];
    logic [7:0] mq1[$];

    initial begin
        rst_n = 0; lv = 0; rdy = 0; d = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v), 0);
        chk("rst_data", 32'(q), 0);
        chk("rst_last", 32'(l), 0);
        chk("rst_load_ready", 32'(lr), 1);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_valid", 32'(v), 0);
        chk("post_rst_load_ready", 32'(lr), 1);

        // lv rdy d : expected valid data last load_ready (outputs seen with these inputs applied)
        tbl[0]  = '{1, 1, V1, 0, 8'h00, 0, 1};
        tbl[1]  = '{0, 1, V1, 1, 8'h44, 0, 0};
        tbl[2]  = '{0, 0, V1, 1, 8'h33, 0, 0};
        tbl[3]  = '{0, 0, V1, 1, 8'h33, 0, 0};
        tbl[4]  = '{0, 1, V1, 1, 8'h33, 0, 0};
        tbl[5]  = '{0, 1, V1, 1, 8'h22, 0, 0};
        tbl[6]  = '{1, 1, V2, 1, 8'h11, 1, 1};
        tbl[7]  = '{0, 1, V2, 1, 8'h0D, 0, 0};
        tbl[8]  = '{0, 1, V2, 1, 8'h0C, 0, 0};
        tbl[9]  = '{0, 1, V2, 1, 8'h0B, 0, 0};
        tbl[10] = '{0, 1, V2, 1, 8'h0A, 1, 1};
        tbl[11] = '{1, 1, V1, 0, 8'h0A, 0, 1};
        tbl[12] = '{0, 1, V2, 1, 8'h44, 0, 0};
        tbl[13] = '{0, 1, V2, 1, 8'h33, 0, 0};
        tbl[14] = '{0, 1, V2, 1, 8'h22, 0, 0};
        tbl[15] = '{1, 0, V2, 1, 8'h11, 1, 0};
        tbl[16] = '{0, 1, V2, 1, 8'h11, 1, 1};
        tbl[17] = '{0, 1, V2, 0, 8'h11, 0, 1};
        for (int i = 0; i < 18; i++) begin
            lv = tbl[i].lv; rdy = tbl[i].rdy; d = tbl[i].d;
            #1;
            chk($sformatf("row%0d_valid", i), 32'(v), 32'(tbl[i].v));
            chk($sformatf("row%0d_data", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("row%0d_last", i), 32'(l), 32'(tbl[i].l));
            chk($sformatf("row%0d_load_ready", i), 32'(lr), 32'(tbl[i].lr));
            if (i == 7) chk("roundtrip_v1", sr, V1);
            @(negedge clk);
        end
        chk("roundtrip_final", sr, V1);

        // Randomized traffic against queue models (DEPTH=4 and DEPTH=1 share inputs)
        for (int c = 0; c < 400; c++) begin
            lv  = 1'($urandom_range(0, 1));
            rdy = $urandom_range(0, 3) != 0;
            d   = $urandom;
            #1;
            chk("rnd_valid", 32'(v), 32'(mq.size() > 0));
            chk("rnd_load_ready", 32'(lr), 32'(mq.size() == 0 || (rdy && mq.size() == 1)));
            if (mq.size() > 0) begin
                chk("rnd_data", 32'(q), 32'(mq[0]));
                chk("rnd_last", 32'(l), 32'(mq.size() == 1));
            end
            chk("d1_valid", 32'(v1), 32'(mq1.size() > 0));
            chk("d1_last_eq_valid", 32'(l1), 32'(v1));
            chk("d1_load_ready", 32'(lr1), 32'(mq1.size() == 0 || rdy));
            if (mq1.size() > 0) chk("d1_data", 32'(q1), 32'(mq1[0]));
            begin
                automatic bit ld  = lv && (mq.size() == 0 || (rdy && mq.size() == 1));
                automatic bit ld1 = lv && (mq1.size() == 0 || rdy);
                if (mq.size() > 0 && rdy) void'(mq.pop_front());
                if (mq1.size() > 0 && rdy) void'(mq1.pop_front());
                if (ld) for (int k = 3; k >= 0; k--) mq.push_back(d[k*8 +: 8]);
                if (ld1) mq1.push_back(d[7:0]);
            end
            @(negedge clk);
        end

        // Drain, then reset in the middle of a vector
        lv = 0; rdy = 1;
        repeat (6) @(negedge clk);
        lv = 1; d = V1;
        @(negedge clk);
        lv = 0; d = V2;
        repeat (2) @(negedge clk);
        chk("midrst_before_data", 32'(q), 32'h22);
        rst_n = 0;
        #1;
        chk("midrst_valid", 32'(v), 0);
        chk("midrst_data", 32'(q), 0);
        chk("midrst_last", 32'(l), 0);
        chk("midrst_load_ready", 32'(lr), 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("after_rst_valid", 32'(v), 0);
            chk("after_rst_load_ready", 32'(lr), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer: accepts a DEPTH-word vector in one handshake and emits it one WIDTH-bit word per beat over a valid/ready stream. It drives the input of the team's serial delay-line `shift_register`. Word order is chosen so that, after DEPTH beats are shifted into a `shift_register` of equal DEPTH, that register's storage equals the loaded vector index-for-index. This lets wide coefficient and pixel vectors be streamed into the delay-line pipeline.

## Interface
Parameters:
- WIDTH, default 1, bits per word
- DEPTH, default 1, words per vector (≥1)

Ports:
- i_clk  input  1  the single clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous and active-low
- i_load_valid  input  1  load vector is valid
- i_load_data  input  [DEPTH-1:0][WIDTH-1:0]  vector to serialize, packed
- o_load_ready  output  1  serializer can accept a vector this cycle
- o_valid  output  1  o_data holds a valid word
- o_data  output  WIDTH  current serial word
- o_last  output  1  current word is the final word of the vector (index 0)
- i_ready  input  1  downstream accepts the word this cycle

## Operation
- Load handshake: a load occurs when i_load_valid && o_load_ready at a rising edge; i_load_data is captured into an internal DEPTH-word register.
- Out handshake: a beat occurs when o_valid && i_ready at a rising edge.
- FSM, two states:
  - IDLE: o_valid=0. Go to SHIFT on a load.
  - SHIFT: o_valid=1.
- Emission order: word DEPTH-1 first, word 0 last. A down-counter idx is loaded with DEPTH-1 and decremented on each beat. o_data = stored[idx].
- o_last = o_valid && (idx == 0).
- A beat with o_last ends the vector. The FSM returns to IDLE unless a load occurs in the same cycle, in which case it stays in SHIFT with idx = DEPTH-1 and the new vector.
- o_load_ready = (state == IDLE) || (o_valid && i_ready && o_last). This is combinational; i_load_valid has no combinational path to any output.
- Backpressure: while o_valid && !i_ready, o_data, o_last and idx hold and the stored vector is unchanged.
- Width rules:
  - idx is max(1, $clog2(DEPTH)) bits wide.
  - idx never wraps below 0. The decrement happens only when idx != 0.
- DEPTH=1: every word is last, so o_last == o_valid.
- i_load_data is ignored when no load occurs. Changing it mid-vector has no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, idx=0, stored vector = 0, o_valid=0, o_data=0, o_last=0, o_load_ready=1.
- Latency: a load at edge N gives o_valid=1 with word DEPTH-1 during cycle N+1.
- Throughput: with i_ready held at 1 and back-to-back loads, one word per cycle and no bubble between vectors. DEPTH beats per vector.
- Reset mid-vector: the remaining words are dropped and the outputs take their reset values immediately. No partial vector is emitted after release.
- Load during an unaccepted final beat (o_last=1, i_ready=0): o_load_ready=0, so no load occurs.

## Structure
- Shared package piso_pkg holds state_t, an enum of IDLE and SHIFT.
- No sub-module. One file with the FSM, the down-counter and the vector register. The counter and vector are clock-enabled by the load and beat conditions.

## Test plan
- Reset check: hold i_rst_n=0 for 3 cycles, then release → o_valid=0, o_data=0, o_last=0, o_load_ready=1.
- Single vector, no stall, WIDTH=8, DEPTH=4: load {3:0x44, 2:0x33, 1:0x22, 0:0x11}, i_ready=1 → cycles N+1..N+4 show o_data 0x44, 0x33, 0x22, 0x11; o_last only on 0x11; o_load_ready=0 in cycles N+1..N+3.
- Backpressure: same vector, drop i_ready for 2 cycles while 0x33 is presented → 0x33 holds with o_valid=1 for 3 cycles, then 0x22 and 0x11 follow; no word lost or duplicated.
- Back-to-back: load a second vector {0xD,0xC,0xB,0xA} during the 0x11 beat → next cycle o_data=0xD, o_valid stays high, 8 contiguous beats.
- Round-trip and edge cases:
  - Feed o_data into `shift_register` (WIDTH=8, DEPTH=4) with i_shift = o_valid && i_ready. After 4 beats its contents equal the loaded vector index-for-index.
  - DEPTH=1: every beat has o_last=1.
- Reset mid-vector: assert i_rst_n=0 after the 2nd beat → o_valid drops immediately; after release, o_load_ready=1 and no further words are emitted.
